cell_plotter: RTL and testbench
===============================

CELL_PLOTTER -- requirements
Module: cell_plotter

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: change-record queue depth; power of two.
REQ-002 Parameter CELL_SIZE, default 8: edge length of one cell in pixels; power of two.
REQ-003 Parameter GRID_DIM, default 4: cells per grid row and per grid column.
REQ-004 Parameter X_ORIGIN, default 0: screen x of the grid's top-left pixel.
REQ-005 Parameter Y_ORIGIN, default 0: screen y of the grid's top-left pixel.
REQ-006 Port clock  in  1: single clock; every flop is on its rising edge.
REQ-007 Port reset  in  1: synchronous reset, active-high.
REQ-008 Port in_valid  in  1: a change record is offered.
REQ-009 Port in_ready  out  1: the block can accept a record.
REQ-010 Port in_cell_x  in  8: column of the changed cell.
REQ-011 Port in_cell_y  in  8: row of the changed cell.
REQ-012 Port in_colour  in  3: new colour of the cell.
REQ-013 Port out_x  out  8: pixel x to the VGA adapter.
REQ-014 Port out_y  out  8: pixel y to the VGA adapter.
REQ-015 Port out_colour  out  3: pixel colour to the VGA adapter.
REQ-016 Port plot  out  1: pixel write strobe to the VGA adapter.
REQ-017 Port busy  out  1: a record is queued or being drawn.
REQ-018 Port drop  out  1: one-cycle pulse when an out-of-range record is discarded.

Function
REQ-019 A record SHALL be accepted on any rising edge where in_valid and in_ready are both 1.
REQ-020 in_ready SHALL equal NOT fifo_full; a pop in the same cycle SHALL NOT make room for a push.
REQ-021 An accepted record with in_cell_x >= GRID_DIM or in_cell_y >= GRID_DIM SHALL NOT be stored; drop SHALL be high for the one cycle after the accepting edge.
REQ-022 In-range records SHALL be stored in FIFO order; none lost, none duplicated.
REQ-023 FSM states SHALL be IDLE and DRAW.
REQ-024 IDLE with FIFO non-empty SHALL pop the head record into draw registers on the next edge and enter DRAW; the pixel counters SHALL be zeroed.
REQ-025 DRAW SHALL last exactly CELL_SIZE*CELL_SIZE cycles, with plot=1 in every one of them.
REQ-026 Pixel order SHALL be row-major: px advances fastest, and py increments when px wraps from CELL_SIZE-1 to 0.
REQ-027 For each DRAW pixel: out_x = X_ORIGIN + cell_x*CELL_SIZE + px, and out_y = Y_ORIGIN + cell_y*CELL_SIZE + py.
REQ-028 For each DRAW pixel, out_colour SHALL equal the record's colour.
REQ-029 Coordinate arithmetic SHALL be 8-bit modulo 256; no saturation.
REQ-030 On the last DRAW pixel, a non-empty FIFO SHALL pop the next record, with DRAW continuing gap-free; an empty FIFO SHALL return the FSM to IDLE.
REQ-031 plot, out_x, out_y and out_colour SHALL be registered outputs.
REQ-032 In IDLE, plot SHALL be 0 and out_x, out_y, out_colour SHALL hold their last values.
REQ-033 Latency: the first plot of a record accepted into an empty, idle block SHALL be high in the cycle after the second rising edge following the accepting edge.
REQ-034 busy SHALL be 1 whenever state = DRAW or the FIFO is non-empty; otherwise 0.
REQ-035 A push and a pop on the same edge SHALL leave the occupancy unchanged.

Reset
REQ-036 After a reset edge: FIFO empty, state IDLE; plot, drop, busy = 0; in_ready = 1; out_x, out_y, out_colour = 0.
REQ-037 Reset asserted mid-DRAW SHALL abandon the current cell and discard all queued records.
REQ-038 Reset SHALL override a simultaneous push.

Verification
REQ-039 Push (1,2,7), defaults -> 64 consecutive plot cycles; first pixel (8,16), last (15,23), colour 7; then plot=0, busy=0.
REQ-040 Push (0,0,7) then (3,3,0) on consecutive edges -> 128 gap-free plot cycles; first cell spans (0,0)-(7,7); second cell spans (24,24)-(31,31) with colour 0.
REQ-041 in_valid held for 20 cycles with distinct in-range cells -> exactly 17 accepted; in_ready=0 until the first cell's draw ends; drawn order equals push order.
REQ-042 Push (4,0,7) -> drop=1 for one cycle; no plot; busy remains 0.
REQ-043 Reset after 10 plots of a cell with 3 records queued -> next cycle plot=0, busy=0, in_ready=1; no further plots.

Source files
------------

// File: rtl/cell_plotter.sv
// Queues cell-change records and paints each as a CELL_SIZE x CELL_SIZE pixel block for a VGA adapter.
// Latency: first plot two edges after a record is accepted into an idle block; one pixel per cycle after that.
// Backpressure: in_ready drops when the record FIFO is full; out-of-range records are discarded with a drop pulse.
module cell_plotter #(
    parameter int FIFO_DEPTH = 16,
    parameter int CELL_SIZE  = 8,
    parameter int GRID_DIM   = 4,
    parameter int X_ORIGIN   = 0,
    parameter int Y_ORIGIN   = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_cell_x,
    input  logic [7:0] in_cell_y,
    input  logic [2:0] in_colour,
    output logic [7:0] out_x,
    output logic [7:0] out_y,
    output logic [2:0] out_colour,
    output logic       plot,
    output logic       busy,
    output logic       drop
);
    localparam int            AW        = $clog2(FIFO_DEPTH);
    localparam int            PW        = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;
    localparam logic [PW-1:0] PIX_MAX   = PW'(CELL_SIZE - 1);
    localparam logic [7:0]    CELL_STEP = 8'(CELL_SIZE);
    localparam logic [7:0]    GRID_LIM  = 8'(GRID_DIM);
    localparam logic [7:0]    X_BASE    = 8'(X_ORIGIN);
    localparam logic [7:0]    Y_BASE    = 8'(Y_ORIGIN);

    typedef struct packed {
        logic [7:0] cell_x;
        logic [7:0] cell_y;
        logic [2:0] colour;
    } rec_t;

    typedef enum logic {IDLE, DRAW} state_t;

    state_t        state_q, state_d;
    rec_t          mem_q [FIFO_DEPTH];
    rec_t          cur_q;
    logic [AW:0]   wr_q, rd_q;
    logic [PW-1:0] px_q, py_q;
    logic [7:0]    out_x_q, out_y_q;
    logic [2:0]    out_colour_q;
    logic          plot_q, drop_q;

    logic fifo_empty, fifo_full, in_range, accept, push, pop, last_pix, draw_pix;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign in_ready   = !fifo_full;
    assign in_range   = (in_cell_x < GRID_LIM) && (in_cell_y < GRID_LIM);
    assign accept     = in_valid && in_ready;
    assign push       = accept && in_range;
    assign last_pix   = (px_q == PIX_MAX) && (py_q == PIX_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = DRAW;
            DRAW:    if (last_pix && fifo_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        draw_pix = (state_q == DRAW);
        pop      = !fifo_empty && ((state_q == IDLE) || (draw_pix && last_pix));
    end

    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem_q[wr_q[AW-1:0]] <= rec_t'{in_cell_x, in_cell_y, in_colour};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q         <= '0;
            rd_q         <= '0;
            cur_q        <= '0;
            px_q         <= '0;
            py_q         <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_colour_q <= '0;
            plot_q       <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) begin
                rd_q  <= rd_q + 1'b1;
                cur_q <= mem_q[rd_q[AW-1:0]];
                px_q  <= '0;
                py_q  <= '0;
            end else if (draw_pix) begin
                px_q <= px_q + 1'b1;
                if (px_q == PIX_MAX) py_q <= py_q + 1'b1;
            end
            // Outputs keep the last pixel while idle so the adapter never sees a glitch.
            plot_q <= draw_pix;
            if (draw_pix) begin
                out_x_q      <= X_BASE + cur_q.cell_x * CELL_STEP + 8'(px_q);
                out_y_q      <= Y_BASE + cur_q.cell_y * CELL_STEP + 8'(py_q);
                out_colour_q <= cur_q.colour;
            end
            drop_q <= accept && !in_range;
        end
    end

    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_colour = out_colour_q;
    assign plot       = plot_q;
    assign drop       = drop_q;
    assign busy       = (state_q == DRAW) || !fifo_empty;

endmodule

// File: tb/tb_cell_plotter.sv
// Bench for cell_plotter: randomized and directed stimulus against a pixel-schedule model.
module tb_cell_plotter;
    localparam int FIFO_DEPTH = 16;
    localparam int CELL_SIZE  = 8;
    localparam int GRID_DIM   = 4;
    localparam int X_ORIGIN   = 0;
    localparam int Y_ORIGIN   = 0;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_cell_x, in_cell_y;
    logic [2:0] in_colour;
    logic [7:0] out_x, out_y;
    logic [2:0] out_colour;
    logic       plot, busy, drop;

    cell_plotter #(
        .FIFO_DEPTH(FIFO_DEPTH), .CELL_SIZE(CELL_SIZE), .GRID_DIM(GRID_DIM),
        .X_ORIGIN(X_ORIGIN), .Y_ORIGIN(Y_ORIGIN)
    ) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_cell_x(in_cell_x), .in_cell_y(in_cell_y), .in_colour(in_colour),
        .out_x(out_x), .out_y(out_y), .out_colour(out_colour),
        .plot(plot), .busy(busy), .drop(drop)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: queued records, plus a time-stamped list of the pixels the adapter must see.
    typedef struct {int x; int y; int c;} rec_t;
    typedef struct {int stamp; int x; int y; int c;} pix_t;

    rec_t q[$];
    pix_t pix_q[$];
    int   t = 0;
    int   draw_end = 0;
    int   last_x = 0, last_y = 0, last_c = 0;
    bit   exp_drop = 0;

    always @(posedge clock) begin
        bit   acc, rng;
        rec_t r;
        pix_t p;
        t++;
        if (reset) begin
            q.delete();
            pix_q.delete();
            draw_end = t;
            exp_drop = 0;
            last_x = 0; last_y = 0; last_c = 0;
        end else begin
            acc = in_valid && (q.size() < FIFO_DEPTH);
            rng = (in_cell_x < GRID_DIM) && (in_cell_y < GRID_DIM);
            // A record starts when the previous cell has finished its last pixel cycle.
            if (q.size() > 0 && t >= draw_end) begin
                r = q.pop_front();
                for (int py = 0; py < CELL_SIZE; py++)
                    for (int px = 0; px < CELL_SIZE; px++) begin
                        p.stamp = t + 1 + py * CELL_SIZE + px;
                        p.x = (X_ORIGIN + r.x * CELL_SIZE + px) % 256;
                        p.y = (Y_ORIGIN + r.y * CELL_SIZE + py) % 256;
                        p.c = r.c;
                        pix_q.push_back(p);
                    end
                draw_end = t + CELL_SIZE * CELL_SIZE;
            end
            if (acc && rng) begin
                r.x = int'(in_cell_x); r.y = int'(in_cell_y); r.c = int'(in_colour);
                q.push_back(r);
            end
            exp_drop = acc && !rng;
        end
        #1;
        check("in_ready", in_ready, (q.size() < FIFO_DEPTH));
        check("busy", busy, (t < draw_end) || (q.size() > 0));
        check("drop", drop, exp_drop);
        if (pix_q.size() > 0 && pix_q[0].stamp == t) begin
            p = pix_q.pop_front();
            check("plot", plot, 1);
            check("out_x", out_x, p.x);
            check("out_y", out_y, p.y);
            check("out_colour", out_colour, p.c);
            last_x = p.x; last_y = p.y; last_c = p.c;
        end else begin
            check("plot", plot, 0);
            check("hold_x", out_x, last_x);
            check("hold_y", out_y, last_y);
            check("hold_colour", out_colour, last_c);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int x, input int y, input int c);
        @(negedge clock);
        in_valid = 1'b1;
        in_cell_x = 8'(x); in_cell_y = 8'(y); in_colour = 3'(c);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || plot) && n < 3000) begin
            tick();
            n++;
        end
        check("idle_timeout", (n < 3000), 1);
    endtask

    // Waits for plot, then counts the gap-free run; reports first/65th/last pixel.
    task automatic measure_run(output int lat, output int cnt, output int fx, output int fy,
                               output int fc, output int mx, output int my, output int mc,
                               output int lx, output int ly);
        lat = 0; cnt = 0; fx = 0; fy = 0; fc = 0; mx = 0; my = 0; mc = 0; lx = 0; ly = 0;
        while (!plot && lat < 200) begin
            tick();
            lat++;
        end
        while (plot && cnt < 3000) begin
            cnt++;
            if (cnt == 1) begin fx = out_x; fy = out_y; fc = out_colour; end
            if (cnt == 65) begin mx = out_x; my = out_y; mc = out_colour; end
            lx = out_x; ly = out_y;
            tick();
        end
    endtask

    initial begin
        int lat, cnt, fx, fy, fc, mx, my, mc, lx, ly, accepted;
        reset = 1'b1; in_valid = 1'b0; in_cell_x = '0; in_cell_y = '0; in_colour = '0;
        tick(); tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_x", out_x, 0);
        @(negedge clock) reset = 1'b0;

        // Single cell with exact latency and corner pixels.
        push(1, 2, 7);
        measure_run(lat, cnt, fx, fy, fc, mx, my, mc, lx, ly);
        check("lat_edges", lat, 2);
        check("cell_len", cnt, 64);
        check("first_x", fx, 8);
        check("first_y", fy, 16);
        check("first_c", fc, 7);
        check("last_x", lx, 15);
        check("last_y", ly, 23);
        check("after_busy", busy, 0);
        wait_idle();

        // Back-to-back records draw gap-free.
        @(negedge clock);
        in_valid = 1'b1; in_cell_x = 8'd0; in_cell_y = 8'd0; in_colour = 3'd7;
        @(negedge clock);
        in_cell_x = 8'd3; in_cell_y = 8'd3; in_colour = 3'd0;
        @(negedge clock) in_valid = 1'b0;
        measure_run(lat, cnt, fx, fy, fc, mx, my, mc, lx, ly);
        check("pair_len", cnt, 128);
        check("pair_first_x", fx, 0);
        check("pair_second_x", mx, 24);
        check("pair_second_y", my, 24);
        check("pair_second_c", mc, 0);
        check("pair_last_x", lx, 31);
        check("pair_last_y", ly, 31);
        wait_idle();

        // Hold in_valid for 20 cycles: FIFO absorbs 16 plus the one already popped.
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_cell_x = 8'(i % 4); in_cell_y = 8'((i / 4) % 4); in_colour = 3'(i % 8);
            if (in_ready) accepted++;
        end
        @(negedge clock) in_valid = 1'b0;
        check("fill_accepted", accepted, 17);
        wait_idle();

        // Out-of-range record is discarded.
        push(4, 0, 7);
        check("oor_drop", drop, 1);
        check("oor_busy", busy, 0);
        tick();
        check("oor_drop_end", drop, 0);
        check("oor_plot", plot, 0);

        // Reset mid-draw with records queued, alongside a simultaneous push.
        for (int i = 0; i < 4; i++) push(i, 3 - i, i + 1);
        cnt = 0;
        lat = 0;
        while (cnt < 10 && lat < 200) begin
            if (plot) cnt++;
            if (cnt < 10) tick();
            lat++;
        end
        check("mid_plots", cnt, 10);
        @(negedge clock);
        reset = 1'b1; in_valid = 1'b1; in_cell_x = 8'd2; in_cell_y = 8'd2; in_colour = 3'd5;
        tick();
        check("mid_rst_plot", plot, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 1);
        @(negedge clock);
        reset = 1'b0; in_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (plot) cnt++;
        end
        check("post_rst_plots", cnt, 0);

        // Random traffic with occasional out-of-range cells and resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            in_valid  = ($urandom_range(0, 3) == 0);
            in_cell_x = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
            in_cell_y = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
            in_colour = 3'($urandom_range(0, 7));
            reset     = ($urandom_range(0, 599) == 0);
        end
        @(negedge clock);
        in_valid = 1'b0; reset = 1'b0;
        wait_idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
